// File: rtl/wb_accel_dispatch.sv
// wb_accel_dispatch: Wishbone B3 classic dispatcher from one upstream master to
// NUM_ACCEL accelerator slaves. The target is decoded from the address
// window, the request is registered, and a single downstream access is issued.
// An accelerator that never answers is cut off after TIMEOUT_CYCLES with an err.
// Optional macro WB_ACCEL_DISPATCH_STATS_EN adds saturating timeout and
// decode-error counters on stat_timeout_cnt_o / stat_decerr_cnt_o.
module wb_accel_dispatch #(
  parameter int                    NUM_ACCEL      = 4,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    WIN_LSB        = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'hE000_0000,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst,
`ifdef WB_ACCEL_DISPATCH_STATS_EN
  output logic [15:0]                       stat_timeout_cnt_o,
  output logic [15:0]                       stat_decerr_cnt_o,
`endif
  input  logic [ADDR_WIDTH-1:0]             wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]             wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0]           wbs_sel_i,
  input  logic                              wbs_we_i,
  input  logic                              wbs_cyc_i,
  input  logic                              wbs_stb_i,
  output logic [DATA_WIDTH-1:0]             wbs_dat_o,
  output logic                              wbs_ack_o,
  output logic                              wbs_err_o,
  output logic [NUM_ACCEL*ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [NUM_ACCEL*DATA_WIDTH-1:0]   wbm_dat_o,
  output logic [NUM_ACCEL*DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [NUM_ACCEL-1:0]              wbm_we_o,
  output logic [NUM_ACCEL-1:0]              wbm_cyc_o,
  output logic [NUM_ACCEL-1:0]              wbm_stb_o,
  input  logic [NUM_ACCEL*DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic [NUM_ACCEL-1:0]              wbm_ack_i,
  input  logic [NUM_ACCEL-1:0]              wbm_err_i,
  output logic                              busy_o,
  output logic                              timeout_o
);

  localparam int SEL_W = (NUM_ACCEL > 1) ? $clog2(NUM_ACCEL) : 1;
  localparam int SB_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] HI_MASK  = {ADDR_WIDTH{1'b1}} << (WIN_LSB + SEL_W);
  localparam logic [SEL_W:0]        NUM_LIM  = (SEL_W+1)'(NUM_ACCEL);
  localparam logic [CNT_W-1:0]      TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  state_q;
  logic [NUM_ACCEL-1:0]    port_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ack_q, err_q, tmo_q;
  logic [DATA_WIDTH-1:0]   rdat_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [SB_W-1:0]         sel_q;
  logic                    we_q;

  logic [SEL_W-1:0]        req_idx;
  logic                    req_valid;
  logic                    req_start;
  logic [NUM_ACCEL-1:0]    req_onehot;
  logic                    rsp_ack, rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_dat;

  // Address decode: window above the index field must match BASE_ADDR, index in range.
  assign req_idx   = wbs_adr_i[WIN_LSB +: SEL_W];
  assign req_valid = (((wbs_adr_i ^ BASE_ADDR) & HI_MASK) == '0) && ({1'b0, req_idx} < NUM_LIM);
  assign req_start = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i;

  // One-hot port select for the decoded index.
  always_comb begin
    req_onehot = '0;
    for (int n = 0; n < NUM_ACCEL; n++) begin
      if (req_idx == SEL_W'(n)) req_onehot[n] = 1'b1;
    end
  end

  // Response mux: only the selected port's ack/err/data are ever observed.
  always_comb begin
    rsp_ack = 1'b0;
    rsp_err = 1'b0;
    rsp_dat = '0;
    for (int n = 0; n < NUM_ACCEL; n++) begin
      if (port_q[n]) begin
        rsp_ack = wbm_ack_i[n];
        rsp_err = wbm_err_i[n];
        rsp_dat = wbm_dat_i[n*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Request payload capture; qualified by port_q downstream so no reset is needed.
  always_ff @(posedge clk) begin
    if (req_start) begin
      adr_q <= wbs_adr_i;
      dat_q <= wbs_dat_i;
      sel_q <= wbs_sel_i;
      we_q  <= wbs_we_i;
    end
  end

  // Dispatch FSM with registered upstream response and downstream port select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdat_q <= '0;
          if (req_start) begin
            if (req_valid) begin
              state_q <= ISSUE;
              port_q  <= req_onehot;
              cnt_q   <= '0;
            end else begin
              state_q <= RESP;
              err_q   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          // A master that has withdrawn gets no response at all.
          if (!wbs_cyc_i) begin
            state_q <= IDLE;
            port_q  <= '0;
          end else if (rsp_err) begin
            state_q <= RESP;
            port_q  <= '0;
            err_q   <= 1'b1;
          end else if (rsp_ack) begin
            state_q <= RESP;
            port_q  <= '0;
            ack_q   <= 1'b1;
            rdat_q  <= we_q ? '0 : rsp_dat;
          end else if (cnt_q == TMO_LAST) begin
            state_q <= RESP;
            port_q  <= '0;
            err_q   <= 1'b1;
            tmo_q   <= 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          rdat_q  <= '0;
        end
        default: begin
          state_q <= IDLE;
          port_q  <= '0;
        end
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = rdat_q;
  assign timeout_o = tmo_q;
  assign busy_o    = (state_q != IDLE);
  assign wbm_cyc_o = port_q;
  assign wbm_stb_o = port_q;

  for (genvar n = 0; n < NUM_ACCEL; n++) begin : g_port
    assign wbm_adr_o[n*ADDR_WIDTH +: ADDR_WIDTH] = port_q[n] ? adr_q : '0;
    assign wbm_dat_o[n*DATA_WIDTH +: DATA_WIDTH] = port_q[n] ? dat_q : '0;
    assign wbm_sel_o[n*SB_W +: SB_W]             = port_q[n] ? sel_q : '0;
    assign wbm_we_o[n]                           = port_q[n] & we_q;
  end

`ifdef WB_ACCEL_DISPATCH_STATS_EN
  logic [15:0] stat_tmo_q, stat_dec_q;
  logic        decerr_evt;

  assign decerr_evt = req_start && !req_valid;

  // Saturating event counters for timeouts and decode errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_tmo_q <= '0;
      stat_dec_q <= '0;
    end else begin
      if (tmo_q && (stat_tmo_q != 16'hFFFF))      stat_tmo_q <= stat_tmo_q + 16'd1;
      if (decerr_evt && (stat_dec_q != 16'hFFFF)) stat_dec_q <= stat_dec_q + 16'd1;
    end
  end

  assign stat_timeout_cnt_o = stat_tmo_q;
  assign stat_decerr_cnt_o  = stat_dec_q;
`endif

endmodule
